ysyx_rob_ring: RTL and testbench

- Parametrised reorder-buffer ring for the out-of-order backend.
- Allocates entries in program order at dispatch and accepts out-of-order completion from NWB writeback channels.
- Retires entries in order, one per cycle, to the commit stage.
- Each entry holds an opaque dispatch payload plus writeback results (npc, trap, cause). Per-entry state uses the ROB_CM / ROB_WB / ROB_EX encoding of rob_state_t.

---
 rtl/ysyx_rob_ring.sv | 178 +++++++++++++++++
 tb/tb_ysyx_rob_ring.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rob_ring.sv
// ysyx_rob_ring: reorder-buffer ring. Allocates entries in order, takes writebacks
// out of order and retires them in order.
// Optional macro YSYX_ROB_WB_BYPASS_EN: forward a writeback that targets the head
// straight to the commit port, so the entry can retire in the same cycle.
module ysyx_rob_ring #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NWB       = 2,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IW        = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   disp_valid_i,
    output logic                   disp_ready_o,
    input  logic [PAYLOAD_W-1:0]   disp_payload_i,
    output logic [IW-1:0]          disp_idx_o,
    input  logic [NWB-1:0]         wb_valid_i,
    input  logic [NWB*IW-1:0]      wb_idx_i,
    input  logic [NWB*XLEN-1:0]    wb_npc_i,
    input  logic [NWB-1:0]         wb_trap_i,
    input  logic [NWB*XLEN-1:0]    wb_cause_i,
    output logic                   cm_valid_o,
    input  logic                   cm_ready_i,
    output logic [IW-1:0]          cm_idx_o,
    output logic [PAYLOAD_W-1:0]   cm_payload_o,
    output logic [XLEN-1:0]        cm_npc_o,
    output logic                   cm_trap_o,
    output logic [XLEN-1:0]        cm_cause_o,
    output logic [IW:0]            count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = IW + 1;

    typedef enum logic [1:0] {
        ROB_CM = 2'd0,
        ROB_WB = 2'd1,
        ROB_EX = 2'd2
    } rob_state_t;

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    rob_state_t           state_q   [DEPTH];
    rob_state_t           state_d   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [XLEN-1:0]      npc_q     [DEPTH];
    logic [XLEN-1:0]      npc_d     [DEPTH];
    logic                 trap_q    [DEPTH];
    logic                 trap_d    [DEPTH];
    logic [XLEN-1:0]      cause_q   [DEPTH];
    logic [XLEN-1:0]      cause_d   [DEPTH];

    logic [IW-1:0]        head_idx_c;
    logic [IW-1:0]        tail_idx_c;
    logic                 full_c;
    logic                 empty_c;
    logic                 disp_fire_c;
    logic                 cm_fire_c;
    logic [IW-1:0]        wb_idx_c [NWB];
    logic [NWB-1:0]       wb_win_c;

    // Ring pointer status; the wrap bit separates full from empty.
    always_comb begin
        head_idx_c = head_q[IW-1:0];
        tail_idx_c = tail_q[IW-1:0];
        empty_c    = (head_q == tail_q);
        full_c     = (head_idx_c == tail_idx_c) && (head_q[IW] != tail_q[IW]);
    end

    assign count_o      = tail_q - head_q;
    assign empty_o      = empty_c;
    assign full_o       = full_c;
    assign disp_ready_o = !full_c && !flush_i;
    assign disp_idx_o   = tail_idx_c;
    assign disp_fire_c  = disp_valid_i && disp_ready_o;
    assign cm_idx_o     = head_idx_c;
    assign cm_fire_c    = cm_valid_o && cm_ready_i && !flush_i;

    // Writeback arbitration: only executing entries accept, lowest channel wins a collision.
    always_comb begin
        wb_win_c = '0;
        for (int k = 0; k < NWB; k++) begin
            wb_idx_c[k] = wb_idx_i[k*IW +: IW];
        end
        for (int k = 0; k < NWB; k++) begin
            wb_win_c[k] = wb_valid_i[k] && (state_q[wb_idx_c[k]] == ROB_EX);
            for (int j = 0; j < k; j++) begin
                if (wb_valid_i[j] && (wb_idx_c[j] == wb_idx_c[k])) begin
                    wb_win_c[k] = 1'b0;
                end
            end
        end
    end

    // Commit view of the head entry, optionally forwarding a same-cycle writeback.
    always_comb begin
        cm_valid_o   = !empty_c && (state_q[head_idx_c] == ROB_WB);
        cm_payload_o = payload_q[head_idx_c];
        cm_npc_o     = npc_q[head_idx_c];
        cm_trap_o    = trap_q[head_idx_c];
        cm_cause_o   = cause_q[head_idx_c];
`ifdef YSYX_ROB_WB_BYPASS_EN
        for (int k = NWB - 1; k >= 0; k--) begin
            if (wb_win_c[k] && (wb_idx_c[k] == head_idx_c)) begin
                cm_valid_o = !empty_c;
                cm_npc_o   = wb_npc_i[k*XLEN +: XLEN];
                cm_trap_o  = wb_trap_i[k];
                cm_cause_o = wb_cause_i[k*XLEN +: XLEN];
            end
        end
`endif
    end

    // Next-state: flush clears the ring, otherwise dispatch, writeback, then commit.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        state_d   = state_q;
        payload_d = payload_q;
        npc_d     = npc_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = ROB_CM;
            end
        end else begin
            if (disp_fire_c) begin
                payload_d[tail_idx_c] = disp_payload_i;
                state_d[tail_idx_c]   = ROB_EX;
                trap_d[tail_idx_c]    = 1'b0;
                tail_d                = tail_q + PTR_W'(1);
            end
            for (int k = 0; k < NWB; k++) begin
                if (wb_win_c[k]) begin
                    npc_d[wb_idx_c[k]]   = wb_npc_i[k*XLEN +: XLEN];
                    trap_d[wb_idx_c[k]]  = wb_trap_i[k];
                    cause_d[wb_idx_c[k]] = wb_cause_i[k*XLEN +: XLEN];
                    state_d[wb_idx_c[k]] = ROB_WB;
                end
            end
            if (cm_fire_c) begin
                state_d[head_idx_c] = ROB_CM;
                head_d              = head_q + PTR_W'(1);
            end
        end
    end

    // State registers; reset also zeroes entry data so the commit port reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]   <= ROB_CM;
                payload_q[i] <= '0;
                npc_q[i]     <= '0;
                trap_q[i]    <= 1'b0;
                cause_q[i]   <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            state_q   <= state_d;
            payload_q <= payload_d;
            npc_q     <= npc_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_ysyx_rob_ring.sv
// Testbench for ysyx_rob_ring: directed scenarios plus random traffic, checked by a
// scoreboard of dispatched entries against a list-level model of the ring.
module tb_ysyx_rob_ring;

    localparam int DEPTH = 16;
    localparam int NWB   = 2;
    localparam int PW    = 64;
    localparam int XLEN  = 32;
    localparam int IW    = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush_i = 1'b0;
    logic                 disp_valid_i = 1'b0;
    logic                 disp_ready_o;
    logic [PW-1:0]        disp_payload_i = '0;
    logic [IW-1:0]        disp_idx_o;
    logic [NWB-1:0]       wb_valid_i = '0;
    logic [NWB*IW-1:0]    wb_idx_i = '0;
    logic [NWB*XLEN-1:0]  wb_npc_i = '0;
    logic [NWB-1:0]       wb_trap_i = '0;
    logic [NWB*XLEN-1:0]  wb_cause_i = '0;
    logic                 cm_valid_o;
    logic                 cm_ready_i = 1'b0;
    logic [IW-1:0]        cm_idx_o;
    logic [PW-1:0]        cm_payload_o;
    logic [XLEN-1:0]      cm_npc_o;
    logic                 cm_trap_o;
    logic [XLEN-1:0]      cm_cause_o;
    logic [IW:0]          count_o;
    logic                 empty_o;
    logic                 full_o;

    ysyx_rob_ring #(.DEPTH(DEPTH), .NWB(NWB), .PAYLOAD_W(PW), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_payload_i(disp_payload_i), .disp_idx_o(disp_idx_o),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_npc_i(wb_npc_i),
        .wb_trap_i(wb_trap_i), .wb_cause_i(wb_cause_i),
        .cm_valid_o(cm_valid_o), .cm_ready_i(cm_ready_i), .cm_idx_o(cm_idx_o),
        .cm_payload_o(cm_payload_o), .cm_npc_o(cm_npc_o), .cm_trap_o(cm_trap_o),
        .cm_cause_o(cm_cause_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            idx;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: entries are numbered by dispatch order; slot = number mod DEPTH.
    int              m_head = 0;
    int              m_tail = 0;
    bit              m_done  [DEPTH];
    logic [XLEN-1:0] m_npc   [DEPTH];
    logic [XLEN-1:0] m_cause [DEPTH];
    bit              m_trap  [DEPTH];
    bit              exp_ready = 1'b1;
    bit              exp_valid = 1'b0;
    bit              mon_en = 1'b0;

    bit              s_dv, s_cr, s_fl;
    logic [PW-1:0]   s_pl;
    bit              s_wv [NWB];
    int              s_wi [NWB];
    logic [XLEN-1:0] s_wn [NWB];
    logic [XLEN-1:0] s_wc [NWB];
    bit              s_wt [NWB];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_flight(input int idx);
        int off;
        off = (idx - (m_head % DEPTH) + DEPTH) % DEPTH;
        return off < (m_tail - m_head);
    endfunction

    task automatic idle_stim();
        s_dv = 0; s_cr = 0; s_fl = 0; s_pl = '0;
        for (int k = 0; k < NWB; k++) begin
            s_wv[k] = 0; s_wi[k] = 0; s_wn[k] = '0; s_wc[k] = '0; s_wt[k] = 0;
        end
    endtask

    task automatic model_clear();
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict its effects, advance past the clock edge.
    task automatic step();
        int cnt, hidx, tidx;
        bit acc [NWB];
        bit head_acc, dfire, cfire;
        cnt = m_tail - m_head;
        hidx = m_head % DEPTH;
        tidx = m_tail % DEPTH;
        head_acc = 0;
        disp_valid_i   = s_dv;
        disp_payload_i = s_pl;
        cm_ready_i     = s_cr;
        flush_i        = s_fl;
        for (int k = 0; k < NWB; k++) begin
            wb_valid_i[k]               = s_wv[k];
            wb_idx_i[k*IW +: IW]        = IW'(s_wi[k]);
            wb_npc_i[k*XLEN +: XLEN]    = s_wn[k];
            wb_trap_i[k]                = s_wt[k];
            wb_cause_i[k*XLEN +: XLEN]  = s_wc[k];
        end
        for (int k = 0; k < NWB; k++) begin
            acc[k] = s_wv[k] && in_flight(s_wi[k]) && !m_done[s_wi[k]];
            for (int j = 0; j < k; j++)
                if (s_wv[j] && s_wi[j] == s_wi[k]) acc[k] = 0;
            if (acc[k] && s_wi[k] == hidx) head_acc = 1;
        end
        exp_ready = (cnt < DEPTH) && !s_fl;
        exp_valid = (cnt > 0) && m_done[hidx];
`ifdef YSYX_ROB_WB_BYPASS_EN
        if (cnt > 0 && head_acc) exp_valid = 1;
`endif
        dfire = s_dv && exp_ready;
        cfire = exp_valid && s_cr && !s_fl;
        if (!s_fl) begin
            for (int k = 0; k < NWB; k++) begin
                if (acc[k]) begin
                    m_npc[s_wi[k]]   = s_wn[k];
                    m_trap[s_wi[k]]  = s_wt[k];
                    m_cause[s_wi[k]] = s_wc[k];
                end
            end
            if (dfire) exp_q.push_back('{tidx, s_pl});
        end
        @(posedge clock);
        #1;
        if (s_fl) begin
            model_clear();
        end else begin
            for (int k = 0; k < NWB; k++) if (acc[k]) m_done[s_wi[k]] = 1;
            if (cfire) m_head++;
            if (dfire) begin
                m_done[tidx] = 0;
                m_tail++;
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        idle_stim();
        disp_valid_i = 0; cm_ready_i = 0; flush_i = 0; wb_valid_i = '0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        model_clear();
        exp_ready = 1;
        exp_valid = 0;
        mon_en = 1;
    endtask

    task automatic random_stim();
        int cnt;
        cnt = m_tail - m_head;
        s_dv = ($urandom % 4) != 0;
        s_pl = {$urandom, $urandom};
        s_cr = ($urandom % 4) != 0;
        s_fl = ($urandom % 80) == 0;
        for (int k = 0; k < NWB; k++) begin
            s_wv[k] = ($urandom % 2) != 0;
            if (cnt > 0 && ($urandom % 8) != 0)
                s_wi[k] = (m_head + int'($urandom_range(cnt - 1, 0))) % DEPTH;
            else
                s_wi[k] = int'($urandom_range(DEPTH - 1, 0));
            s_wn[k] = $urandom;
            s_wt[k] = ($urandom % 4) == 0;
            s_wc[k] = $urandom;
        end
        if (($urandom % 4) == 0) s_wi[1] = s_wi[0];
    endtask

    // Monitor: status against the model, commits against the scoreboard.
    always @(negedge clock) begin
        if (mon_en) begin
            exp_t e;
            chk("disp_ready", disp_ready_o, exp_ready);
            chk("cm_valid", cm_valid_o, exp_valid);
            chk("count", count_o, m_tail - m_head);
            chk("empty", empty_o, m_tail == m_head);
            chk("full", full_o, (m_tail - m_head) == DEPTH);
            chk("disp_idx", disp_idx_o, m_tail % DEPTH);
            if (cm_valid_o && cm_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: commit idx %0d with nothing expected", cm_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("cm_idx", cm_idx_o, e.idx);
                    chk("cm_payload", cm_payload_o, e.pl);
                    chk("cm_npc", cm_npc_o, m_npc[e.idx]);
                    chk("cm_trap", cm_trap_o, m_trap[e.idx]);
                    chk("cm_cause", cm_cause_o, m_cause[e.idx]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_cm_valid", cm_valid_o, 0);
        chk("rst_disp_ready", disp_ready_o, 1);
        chk("rst_cm_payload", cm_payload_o, 0);
        chk("rst_cm_npc", cm_npc_o, 0);
        chk("rst_cm_cause", cm_cause_o, 0);

        // Three dispatches take slots 0,1,2.
        idle_stim();
        s_dv = 1;
        for (int i = 0; i < 3; i++) begin
            s_pl = {$urandom, $urandom};
            step();
        end
        chk("t1_count", count_o, 3);
        chk("t1_tail", disp_idx_o, 3);

        // Fill to DEPTH, then a rejected extra dispatch.
        do_reset();
        s_dv = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            s_pl = {$urandom, $urandom};
            step();
        end
        chk("t2_full", full_o, 1);
        chk("t2_ready", disp_ready_o, 0);
        chk("t2_count", count_o, DEPTH);
        chk("t2_tail", disp_idx_o, 0);

        // In-order retirement blocked by an unfinished entry.
        do_reset();
        s_dv = 1;
        for (int i = 0; i < 4; i++) begin
            s_pl = {$urandom, $urandom};
            step();
        end
        idle_stim(); s_wv[0] = 1; s_wi[0] = 2; s_wn[0] = 32'h222; step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 0; s_wn[0] = 32'h111; step();
        chk("t3_valid_after_wb", cm_valid_o, 1);
        idle_stim(); s_cr = 1; step();
        chk("t3_blocked", cm_valid_o, 0);
        step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 1; s_wn[0] = 32'h333; step();
        idle_stim(); s_cr = 1; step(); step();
        chk("t3_count", count_o, 1);

        // Same-cycle collision on slot 5, then a late writeback that must be ignored.
        do_reset();
        s_dv = 1;
        for (int i = 0; i < 6; i++) begin
            s_pl = {$urandom, $urandom};
            step();
        end
        idle_stim();
        s_wv[0] = 1; s_wi[0] = 5; s_wn[0] = 32'h100;
        s_wv[1] = 1; s_wi[1] = 5; s_wn[1] = 32'h200;
        step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 5; s_wn[0] = 32'h300; step();
        for (int i = 0; i < 5; i++) begin
            idle_stim(); s_wv[0] = 1; s_wi[0] = i; s_wn[0] = $urandom; step();
        end
        idle_stim(); s_cr = 1;
        for (int i = 0; i < 5; i++) step();
        idle_stim(); step();
        chk("t4_head", cm_idx_o, 5);
        chk("t4_valid", cm_valid_o, 1);
        chk("t4_npc", cm_npc_o, 32'h100);
        s_cr = 1; step();

        // Flush with ten in flight and a simultaneous dispatch.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle_stim();
            s_dv = 1; s_pl = {$urandom, $urandom};
            if (i > 0) begin s_wv[0] = 1; s_wi[0] = i - 1; s_wn[0] = $urandom; end
            step();
        end
        idle_stim(); s_fl = 1; s_dv = 1; s_cr = 1; s_pl = 64'hDEAD_BEEF_0000_0001; step();
        idle_stim(); step();
        chk("t5_count", count_o, 0);
        chk("t5_empty", empty_o, 1);
        chk("t5_valid", cm_valid_o, 0);
        chk("t5_tail", disp_idx_o, 0);
        s_dv = 1; s_pl = 64'h1234_5678_9ABC_DEF0; step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 0; s_wn[0] = 32'h44; step();
        idle_stim(); s_cr = 1; step();

        // Steady occupancy of five across two pointer wraps.
        do_reset();
        s_dv = 1;
        for (int i = 0; i < 5; i++) begin
            s_pl = {$urandom, $urandom};
            step();
        end
        idle_stim(); s_wv[0] = 1; s_wi[0] = 0; s_wn[0] = $urandom; step();
        for (int i = 0; i < 40; i++) begin
            idle_stim();
            s_dv = 1; s_cr = 1; s_pl = {$urandom, $urandom};
            s_wv[0] = 1; s_wi[0] = (m_head + 1) % DEPTH; s_wn[0] = $urandom;
            step();
            chk("t6_count", count_o, 5);
        end
        chk("t6_head", cm_idx_o, 8);
        chk("t6_tail", disp_idx_o, 13);

        // Writeback to the head with commit ready.
        do_reset();
        s_dv = 1; s_pl = {$urandom, $urandom}; step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 0; s_wn[0] = 32'h77; s_cr = 1; step();
`ifdef YSYX_ROB_WB_BYPASS_EN
        chk("t7_count", count_o, 0);
`else
        chk("t7_count", count_o, 1);
`endif

        // Reset in the middle of traffic clears the commit data.
        do_reset();
        idle_stim(); s_dv = 1; s_pl = 64'hA5A5_0000_0000_5A5A; step();
        idle_stim(); s_wv[0] = 1; s_wi[0] = 0; s_wn[0] = 32'hCAFE; s_wc[0] = 32'h9; step();
        do_reset();
        chk("t8_payload", cm_payload_o, 0);
        chk("t8_npc", cm_npc_o, 0);
        chk("t8_cause", cm_cause_o, 0);
        chk("t8_count", count_o, 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            random_stim();
            step();
        end
        idle_stim();
        step();

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
